// File: rtl/echo_seq_ctrl.sv
// echo_seq_ctrl
// Per-sample sequencer for the variable-echo delay RAM. Every rising edge of
// the (synchronized) ADC sample strobe runs one read / capture / write
// transaction against a dual-port RAM:
//   IDLE -> RD (RD_LAT cycles) -> CAP -> WR -> IDLE
// The block owns the circular read pointer and the write offset derived from
// the delay switches, and mutes the echo output for MUTE_SAMPLES samples
// after reset or after any change of the delay setting.
//
// Ports
//   sysclk      in   system clock
//   rst         in   asynchronous active-high reset
//   data_valid  in   ADC sample strobe, asynchronous to sysclk
//   sw          in   requested delay setting (SW_W), asynchronous
//   ram_q       in   RAM read data (DATA_W)
//   ram_raddr   out  RAM read address, registered, held from RD through WR
//   ram_waddr   out  RAM write address = ptr + (active_sw << 4), wraps
//   ram_we      out  RAM write enable, high for the single WR cycle
//   echo_q      out  captured echo sample, zero while muted
//   echo_valid  out  one-cycle pulse in WR: echo_q updated, write in progress
//   busy        out  high in any state other than IDLE
//   overrun     out  sticky: a strobe arrived while busy (cleared by rst)
//   delay       out  active_sw * DELAY_OFFSET, registered (20 bits)
module echo_seq_ctrl #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 9,
  parameter int SW_W         = 9,
  parameter int RD_LAT       = 2,
  parameter int MUTE_SAMPLES = 16,
  parameter int DELAY_OFFSET = 1638
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [SW_W-1:0]   sw,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_we,
  output logic [DATA_W-1:0] echo_q,
  output logic              echo_valid,
  output logic              busy,
  output logic              overrun,
  output logic [19:0]       delay
);

  localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int MUTE_W = $clog2(MUTE_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [MUTE_W-1:0] MUTE_INIT = MUTE_W'(MUTE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  // Write address: read pointer plus the switch setting scaled by 16,
  // truncated so it wraps around the circular buffer.
  function automatic logic [ADDR_W-1:0] wr_addr(input logic [ADDR_W-1:0] ptr,
                                                input logic [SW_W-1:0]   s);
    logic [SW_W+3:0] off;
    off = {s, 4'b0000};
    return ptr + ADDR_W'(off);
  endfunction

  // Echo sample selection: force silence while the buffer still holds
  // samples written under another delay setting (or undefined after reset).
  function automatic logic [DATA_W-1:0] mute_sel(input logic [MUTE_W-1:0] cnt,
                                                 input logic [DATA_W-1:0] d);
    return (cnt != '0) ? '0 : d;
  endfunction

  // Synchronizers: [0],[1] are the 2-FF chain, [2] is the previous
  // synchronized value used for rising-edge detection.
  logic [2:0]        dv_sync_q;
  logic [SW_W-1:0]   sw_s1_q;
  logic [SW_W-1:0]   sw_s2_q;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  rdcnt_q,     rdcnt_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [ADDR_W-1:0] raddr_q,     raddr_d;
  logic [ADDR_W-1:0] waddr_q,     waddr_d;
  logic [DATA_W-1:0] echo_data_q, echo_data_d;
  logic [SW_W-1:0]   active_sw_q, active_sw_d;
  logic [MUTE_W-1:0] mute_q,      mute_d;
  logic              overrun_q,   overrun_d;
  logic [19:0]       delay_q;

  logic              start;
  logic              sw_new;

  assign start  = dv_sync_q[1] & ~dv_sync_q[2];
  assign sw_new = (sw_s2_q != active_sw_q);

  // Input synchronization stage
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      dv_sync_q <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
    end else begin
      dv_sync_q <= {dv_sync_q[1:0], data_valid};
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
    end
  end

  // Sequencer next-state and outputs
  always_comb begin
    state_d     = state_q;
    rdcnt_d     = rdcnt_q;
    ptr_d       = ptr_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    echo_data_d = echo_data_q;
    active_sw_d = active_sw_q;
    mute_d      = mute_q;
    overrun_d   = overrun_q;
    ram_we      = 1'b0;
    echo_valid  = 1'b0;

    // A strobe that lands mid-transaction is dropped but remembered.
    if (start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          // A new delay setting invalidates the buffer contents relative to
          // the new offset, so restart the mute window. The address uses
          // the setting latched now; later switch moves wait for next start.
          if (sw_new) begin
            active_sw_d = sw_s2_q;
            mute_d      = MUTE_INIT;
          end
          raddr_d = ptr_q;
          waddr_d = wr_addr(ptr_q, sw_s2_q);
          rdcnt_d = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (rdcnt_q == RD_LAST) begin
          state_d = CAP;
        end else begin
          rdcnt_d = rdcnt_q + CNT_W'(1);
        end
      end
      CAP: begin
        echo_data_d = mute_sel(mute_q, ram_q);
        state_d     = WR;
      end
      WR: begin
        ram_we     = 1'b1;
        echo_valid = 1'b1;
        ptr_d      = ptr_q + ADDR_W'(1);
        if (mute_q != '0) begin
          mute_d = mute_q - MUTE_W'(1);
        end
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rdcnt_q     <= '0;
      ptr_q       <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      echo_data_q <= '0;
      active_sw_q <= '0;
      mute_q      <= MUTE_INIT;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdcnt_q     <= rdcnt_d;
      ptr_q       <= ptr_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      echo_data_q <= echo_data_d;
      active_sw_q <= active_sw_d;
      mute_q      <= mute_d;
      overrun_q   <= overrun_d;
    end
  end

  // Delay display stage: one cycle behind active_sw
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      delay_q <= '0;
    end else begin
      delay_q <= 20'(active_sw_q) * 20'(DELAY_OFFSET);
    end
  end

  assign ram_raddr = raddr_q;
  assign ram_waddr = waddr_q;
  assign echo_q    = echo_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign delay     = delay_q;

endmodule

// File: tb/tb_echo_seq_ctrl.sv
// Directed testbench for echo_seq_ctrl. Stimulus changes on the falling
// clock edge; outputs are sampled on the falling edge as well.
module tb_echo_seq_ctrl;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [8:0]  sw;
  logic [8:0]  ram_q;
  logic [12:0] ram_raddr;
  logic [12:0] ram_waddr;
  logic        ram_we;
  logic [8:0]  echo_q;
  logic        echo_valid;
  logic        busy;
  logic        overrun;
  logic [19:0] delay;

  int vectors     = 0;
  int miscompares = 0;

  echo_seq_ctrl #(
    .ADDR_W(13), .DATA_W(9), .SW_W(9), .RD_LAT(2),
    .MUTE_SAMPLES(16), .DELAY_OFFSET(1638)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .data_valid(data_valid),
    .sw        (sw),
    .ram_q     (ram_q),
    .ram_raddr (ram_raddr),
    .ram_waddr (ram_waddr),
    .ram_we    (ram_we),
    .echo_q    (echo_q),
    .echo_valid(echo_valid),
    .busy      (busy),
    .overrun   (overrun),
    .delay     (delay)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the WR cycle; leaves us on the falling edge inside it.
  task automatic wait_we(output bit to);
    to = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge sysclk);
      if (ram_we) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // One complete sample transaction; returns the WR-cycle observations.
  task automatic strobe(output logic [12:0] ra, output logic [12:0] wa,
                        output logic [8:0] eq, output logic ev);
    bit to;
    data_valid = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    data_valid = 1'b0;
    wait_we(to);
    chk("strobe_timeout", 32'(to), 32'd0);
    ra = ram_raddr;
    wa = ram_waddr;
    eq = echo_q;
    ev = echo_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] ra, wa;
    logic [8:0]  eq;
    logic        ev;
    bit          to;

    rst        = 1'b0;
    data_valid = 1'b0;
    sw         = 9'd0;
    ram_q      = 9'h0AA;
    #2;

    // ---- Reset state, then 20 strobes with sw=0 ----
    do_reset();
    chk("rst_raddr",   32'(ram_raddr),  0);
    chk("rst_waddr",   32'(ram_waddr),  0);
    chk("rst_we",      32'(ram_we),     0);
    chk("rst_echo",    32'(echo_q),     0);
    chk("rst_evalid",  32'(echo_valid), 0);
    chk("rst_busy",    32'(busy),       0);
    chk("rst_overrun", 32'(overrun),    0);
    chk("rst_delay",   32'(delay),      0);
    for (int i = 0; i < 20; i++) begin
      strobe(ra, wa, eq, ev);
      chk($sformatf("t1_raddr[%0d]", i), 32'(ra), 32'(i));
      chk($sformatf("t1_waddr[%0d]", i), 32'(wa), 32'(i));
      chk($sformatf("t1_echo[%0d]", i),  32'(eq), (i < 16) ? 32'd0 : 32'h0AA);
      chk($sformatf("t1_ev[%0d]", i),    32'(ev), 1);
    end

    // ---- sw=3, single strobe, cycle-exact timing ----
    do_reset();
    sw = 9'd3;
    repeat (3) @(negedge sysclk);
    data_valid = 1'b1;
    @(negedge sysclk); chk("t2_busy_c1", 32'(busy), 0);
    @(negedge sysclk); chk("t2_busy_c2", 32'(busy), 0);
    data_valid = 1'b0;
    @(negedge sysclk); chk("t2_busy_c3", 32'(busy), 1);
    @(negedge sysclk);
    @(negedge sysclk); chk("t2_we_cap",  32'(ram_we), 0);
    @(negedge sysclk);
    chk("t2_we_wr",   32'(ram_we),     1);
    chk("t2_ev_wr",   32'(echo_valid), 1);
    chk("t2_raddr",   32'(ram_raddr),  0);
    chk("t2_waddr",   32'(ram_waddr),  48);
    chk("t2_echo",    32'(echo_q),     0);
    @(negedge sysclk);
    chk("t2_we_after", 32'(ram_we), 0);
    chk("t2_busy_end", 32'(busy),   0);
    chk("t2_delay",    32'(delay),  4914);

    // ---- Overrun: second rise two cycles after a start ----
    data_valid = 1'b1;
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk); data_valid = 1'b1;
    @(negedge sysclk); data_valid = 1'b0;
    wait_we(to);
    chk("t4_timeout", 32'(to),        0);
    chk("t4_raddr",   32'(ram_raddr), 1);
    chk("t4_waddr",   32'(ram_waddr), 49);
    chk("t4_overrun", 32'(overrun),   1);
    strobe(ra, wa, eq, ev);
    chk("t4_next_raddr", 32'(ra),      2);
    chk("t4_sticky",     32'(overrun), 1);

    // ---- sw change mid-transaction ----
    do_reset();
    chk("t5_overrun_clr", 32'(overrun), 0);
    sw    = 9'd5;
    ram_q = 9'h155;
    repeat (3) @(negedge sysclk);
    for (int i = 0; i < 17; i++) begin
      strobe(ra, wa, eq, ev);
      chk($sformatf("t5a_raddr[%0d]", i), 32'(ra), 32'(i));
      chk($sformatf("t5a_echo[%0d]", i),  32'(eq), (i < 16) ? 32'd0 : 32'h155);
    end
    data_valid = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk); sw = 9'd7;
    wait_we(to);
    chk("t5_timeout", 32'(to),        0);
    chk("t5_raddr",   32'(ram_raddr), 17);
    chk("t5_waddr",   32'(ram_waddr), 97);
    chk("t5_echo",    32'(echo_q),    32'h155);
    for (int i = 0; i < 17; i++) begin
      strobe(ra, wa, eq, ev);
      chk($sformatf("t5b_raddr[%0d]", i), 32'(ra), 32'(18 + i));
      chk($sformatf("t5b_waddr[%0d]", i), 32'(wa), 32'(18 + i + 112));
      chk($sformatf("t5b_echo[%0d]", i),  32'(eq), (i < 16) ? 32'd0 : 32'h155);
    end
    chk("t5_delay", 32'(delay), 11466);

    // ---- Reset asserted during WR ----
    data_valid = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk); data_valid = 1'b0;
    wait_we(to);
    chk("t6_timeout", 32'(to),     0);
    chk("t6_we_pre",  32'(ram_we), 1);
    rst = 1'b1;
    #1;
    chk("t6_we",      32'(ram_we),     0);
    chk("t6_ev",      32'(echo_valid), 0);
    chk("t6_busy",    32'(busy),       0);
    chk("t6_overrun", 32'(overrun),    0);
    chk("t6_raddr",   32'(ram_raddr),  0);
    chk("t6_waddr",   32'(ram_waddr),  0);
    chk("t6_echo",    32'(echo_q),     0);
    chk("t6_delay",   32'(delay),      0);
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    strobe(ra, wa, eq, ev);
    chk("t6_post_raddr", 32'(ra), 0);
    chk("t6_post_waddr", 32'(wa), 112);
    chk("t6_post_echo",  32'(eq), 0);

    // ---- Pointer wrap with sw=0x1FF ----
    do_reset();
    sw    = 9'h1FF;
    ram_q = 9'h0AA;
    repeat (3) @(negedge sysclk);
    for (int i = 0; i < 8193; i++) begin
      strobe(ra, wa, eq, ev);
      if (i == 0 || i == 8191 || i == 8192) begin
        chk($sformatf("t3_raddr[%0d]", i), 32'(ra), 32'(i % 8192));
        chk($sformatf("t3_waddr[%0d]", i), 32'(wa), 32'((i + 8176) % 8192));
      end
    end
    chk("t3_echo_last", 32'(eq),    32'h0AA);
    chk("t3_delay",     32'(delay), 837018);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/echo_seq_ctrl.md
Name: echo_seq_ctrl

Overview:
Per-sample sequencer for the variable-echo delay RAM (13-bit address, 9-bit data, dual-port). On each ADC sample strobe it runs one read / capture / write transaction. It owns the circular read pointer and the write offset derived from the delay switches. It mutes the echo path for a fixed number of samples after reset or any delay change, so stale RAM contents never reach the output.

Parameters:
ADDR_W, 13, RAM address width; pointer wraps modulo 2^ADDR_W
DATA_W, 9, RAM data width
SW_W, 9, delay switch width; write offset = sw << 4
RD_LAT, 2, RAM read latency in sysclk cycles (>=1)
MUTE_SAMPLES, 16, samples muted after reset or delay change
DELAY_OFFSET, 1638, delay display scale per switch LSB

Ports:
sysclk  in  1  system clock
rst  in  1  asynchronous active-high reset
data_valid  in  1  ADC sample strobe, asynchronous to sysclk
sw  in  SW_W  requested delay setting, asynchronous
ram_q  in  DATA_W  RAM read data
ram_raddr  out  ADDR_W  RAM read address
ram_waddr  out  ADDR_W  RAM write address
ram_we  out  1  RAM write enable; datapath supplies write data
echo_q  out  DATA_W  captured echo sample, zero while muted
echo_valid  out  1  one-cycle pulse: echo_q updated, write in progress
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a strobe arrived while busy
delay  out  20  active_sw * DELAY_OFFSET, registered

Behaviour:
- data_valid and sw each pass through a 2-FF synchronizer. A start is the rising edge of synchronized data_valid.
- FSM states: IDLE, RD, CAP, WR.
- IDLE, start seen (cycle 0):
  - if sw_sync != active_sw: load active_sw <= sw_sync and mute_cnt <= MUTE_SAMPLES.
  - go to RD.
- RD: occupies cycles 1..RD_LAT.
  - ram_raddr = ptr.
  - ram_waddr = ptr + (active_sw << 4), truncated to ADDR_W (wraps).
- CAP (cycle RD_LAT+1): echo_q <= (mute_cnt != 0) ? 0 : ram_q.
- WR (cycle RD_LAT+2):
  - ram_we = 1 for exactly this cycle; echo_valid = 1.
  - ptr <= ptr + 1, wrapping 2^ADDR_W-1 -> 0.
  - if mute_cnt != 0: mute_cnt decrements.
  - next state IDLE.
- Sample turnaround: RD_LAT+3 cycles. A start in any non-IDLE state is dropped and sets overrun. overrun clears only on rst.
- Addresses: ram_raddr and ram_waddr are registered and held constant from RD through WR. They hold their last values in IDLE.
- Write offset uses the active_sw latched in cycle 0. A sw change mid-transaction takes effect at the next start.
- delay: updates one cycle after active_sw changes. Computed at 20-bit width, no overflow for SW_W=9 (511*1638=837018).
- Reset (async, any state including mid-transaction):
  - state IDLE; ram_we, echo_valid, busy, overrun = 0.
  - ptr = 0, ram_raddr = ram_waddr = 0, echo_q = 0.
  - active_sw = 0, delay = 0, synchronizers cleared.
  - mute_cnt = MUTE_SAMPLES, since RAM content is undefined after reset.
- Mute applies only to echo_q. The RAM write still occurs, so the buffer refills during mute.
- Start and mute-load in the same cycle as mute expiry: the reload wins (mute_cnt = MUTE_SAMPLES).

Test Plan:
- Reset then 20 strobes with sw=0 and ram_q=9'h0AA:
  - echo_q = 0 on the first 16 echo_valid pulses, 9'h0AA from the 17th.
  - ram_raddr = ram_waddr = 0..19.
- sw=9'd3, one strobe after reset:
  - RD starts 3 cycles after the data_valid rise (2 sync + edge).
  - ram_waddr = 48 and ram_raddr = 0; ram_we high exactly at RD_LAT+2; delay = 4914.
- Pointer wrap: 8192 strobes with sw=9'h1FF:
  - ptr goes 8191 -> 0.
  - at ptr=8191, ram_waddr = (8191+8176) mod 8192 = 8175.
- Second data_valid rise 2 cycles after a start:
  - transaction completes unaltered and overrun = 1.
  - overrun stays set until rst.
- sw changes mid-transaction:
  - current ram_waddr is unchanged.
  - the next start reloads mute; echo_q = 0 for the next 16 samples.
- rst asserted during WR:
  - ram_we drops in the same cycle (async); all outputs are at reset values.
  - the next strobe after rst release reads address 0.
